// File: rtl/count_ones.sv
// count_ones: registered 32-bit population count built from a balanced adder tree,
// with asynchronous reset assertion and a two-flop synchronised release.
module count_ones (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in,
    output logic [5:0]  count
);
    logic [1:0] l1 [16];
    logic [2:0] l2 [8];
    logic [3:0] l3 [4];
    logic [4:0] l4 [2];
    logic [5:0] l5;
    logic [1:0] sync_q;
    logic [5:0] count_d, count_q;
    always_comb begin
        for (int i = 0; i < 16; i++) l1[i] = {1'b0, in[2*i]} + {1'b0, in[2*i+1]};
        for (int i = 0; i < 8; i++) l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
        for (int i = 0; i < 4; i++) l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
        for (int i = 0; i < 2; i++) l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
        l5 = {1'b0, l4[0]} + {1'b0, l4[1]};
    end
    // count stays cleared until the synchronised reset has been released
    assign count_d = sync_q[1] ? l5 : 6'd0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b00;
            count_q <= 6'd0;
        end else begin
            sync_q  <= {sync_q[0], 1'b1};
            count_q <= count_d;
        end
    end
    assign count = count_q;
endmodule

// File: tb/tb_count_ones.sv
// tb_count_ones: scoreboard-driven bench for count_ones.
module tb_count_ones;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in = 32'd0;
    logic [5:0]  count;
    int          vectors = 0;
    int          errors = 0;
    logic [5:0]  exp_q [$];
    logic [5:0]  e;

    count_ones dut (.clk(clk), .reset_n(reset_n), .in(in), .count(count));

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_pop(input logic [31:0] v);
        logic [5:0] s = 6'd0;
        for (int b = 0; b < 32; b++) if (v[b]) s = s + 6'd1;
        return s;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        in = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (count !== 6'd0) begin errors++; $display("FAIL reset_hold: count=%0d want 0", count); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (count !== 6'd0) begin errors++; $display("FAIL reset_sync_first_edge: count=%0d want 0", count); end
        for (int k = 0; k < 3 && count !== 6'd32; k++) begin @(posedge clk); #1; end
        vectors++;
        if (count !== 6'd32) begin errors++; $display("FAIL reset_release: count=%0d want 32", count); end
    endtask

    task automatic test_directed();
        logic [31:0] vin [7] = '{32'h000F_FFFF, 32'h0008_F56F, 32'h000D_3FFF, 32'h0001_0001,
                                 32'h0000_F10F, 32'h0005_7822, 32'h000F_7ABC};
        logic [5:0]  vex [7] = '{6'd20, 6'd13, 6'd17, 6'd2, 6'd9, 6'd8, 6'd14};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            in = vin[k];
            exp_q.push_back(vex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (count !== e) begin errors++; $display("FAIL directed[%0d] in=%h: count=%0d want %0d", k, vin[k], count, e); end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] vin [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        logic [5:0]  vex [4] = '{6'd0, 6'd32, 6'd1, 6'd1};
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            in = (k < 4) ? vin[k] : (32'd1 << (k - 4));
            exp_q.push_back((k < 4) ? vex[k] : 6'd1);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (count !== e) begin errors++; $display("FAIL extremes[%0d] in=%h: count=%0d want %0d", k, in, count, e); end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        in = 32'h1234_5678;
        exp_q.push_back(6'd13);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (count !== e) begin errors++; $display("FAIL hold[%0d]: count=%0d want %0d", k, count, e); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        in = 32'hF0F0_0000;
        exp_q.push_back(6'd8);
        #1;
        vectors++;
        if (count !== 6'd13) begin errors++; $display("FAIL hold_comb_change: count=%0d want 13", count); end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        vectors++;
        if (count !== e) begin errors++; $display("FAIL hold_next_edge: count=%0d want %0d", count, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            r = $urandom;
            in = r;
            exp_q.push_back(ref_pop(r));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (count !== e) begin errors++; $display("FAIL random[%0d] in=%h: count=%0d want %0d", k, r, count, e); end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in = 32'hAAAA_AAAA;
        exp_q.push_back(6'd16);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        vectors++;
        if (count !== e) begin errors++; $display("FAIL mid_pre: count=%0d want %0d", count, e); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (count !== 6'd0) begin errors++; $display("FAIL mid_async_clear: count=%0d want 0", count); end
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (count !== 6'd0) begin errors++; $display("FAIL mid_hold[%0d]: count=%0d want 0", k, count); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (count !== 6'd0) begin errors++; $display("FAIL mid_sync_first_edge: count=%0d want 0", count); end
        for (int k = 0; k < 3 && count !== 6'd16; k++) begin @(posedge clk); #1; end
        vectors++;
        if (count !== 6'd16) begin errors++; $display("FAIL mid_release: count=%0d want 16", count); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_extremes();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
